// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - state encoding and sizing helpers shared by seq_divider
package seq_divider_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam int DEF_W = 16;

  function automatic int cnt_w(input int w);
    return $clog2(2 * w);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring-division iteration
module div_step
  import seq_divider_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] r,
  input  logic         nbit,
  input  logic [W-1:0] d,
  output logic [W-1:0] r_next,
  output logic         q_bit
);

  logic [W:0] trial;

  // The incoming remainder is always below d, so both candidates fit W bits.
  always_comb begin
    trial  = {r, nbit};
    q_bit  = (trial >= {1'b0, d});
    r_next = q_bit ? W'(trial - {1'b0, d}) : trial[W-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, 2W/W -> 2W quotient and W remainder
// SEQ_DIVIDER_SIGNED_EN: two's complement operands with one extra sign-fix cycle
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic [2*W-1:0] quotient,
  output logic [W-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           div_zero
);

  localparam int CW = cnt_w(W);
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam state_t RUN_EXIT = FIX;
`else
  localparam state_t RUN_EXIT = DONE;
`endif

  state_t         state, state_nx;
  logic [2*W-1:0] q_reg;
  logic [W-1:0]   r_reg;  // partial remainder stays below D, so W bits hold it
  logic [W-1:0]   d_reg;
  logic [W-1:0]   r_step;
  logic           q_step;
  logic [CW-1:0]  cnt;
  logic           zero_reg;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic           neg_q;
  logic           neg_r;
`endif

  div_step #(.W(W)) u_step (
    .r      (r_reg),
    .nbit   (q_reg[2*W-1]),
    .d      (d_reg),
    .r_next (r_step),
    .q_bit  (q_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = (divisor == '0) ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) state_nx = RUN_EXIT;
      end
      FIX: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg     <= '0;
      r_reg     <= '0;
      d_reg     <= '0;
      cnt       <= '0;
      zero_reg  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (divisor == '0) begin
            q_reg    <= '1;
            r_reg    <= dividend[W-1:0];
            zero_reg <= 1'b1;
          end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_reg <= dividend[2*W-1] ? -dividend : dividend;
            d_reg <= divisor[W-1] ? -divisor : divisor;
            neg_q <= dividend[2*W-1] ^ divisor[W-1];
            neg_r <= dividend[2*W-1];
`else
            q_reg <= dividend;
            d_reg <= divisor;
`endif
            r_reg    <= '0;
            cnt      <= CW'(2*W-1);
            zero_reg <= 1'b0;
          end
        end
        RUN: begin
          r_reg <= r_step;
          q_reg <= {q_reg[2*W-2:0], q_step};
          cnt   <= cnt - CW'(1);
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
        // Truncation toward zero: remainder follows the dividend's sign.
        FIX: begin
          if (neg_q) q_reg <= -q_reg;
          if (neg_r) r_reg <= -r_reg;
        end
`endif
        DONE: begin
          quotient  <= q_reg;
          remainder <= r_reg;
          div_zero  <= zero_reg;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against an arithmetic model
module tb_seq_divider;

  localparam int W = 16;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int LAT = 2*W+2;
`else
  localparam int LAT = 2*W+1;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic [2*W-1:0] quotient;
  logic [W-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           div_zero;

  seq_divider #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q, held_q, acc_a;
  logic [15:0] exp_r, held_r, acc_b;
  logic        exp_z, held_z;
  int          exp_lat;
  bit          track = 1'b0;
  bit          finished = 1'b0;
  bit          have_result = 1'b0;
  int          nedge = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                output logic [31:0] q, output logic [15:0] r);
`ifdef SEQ_DIVIDER_SIGNED_EN
    int sa, sb;
    sa = a;
    sb = int'($signed(b));
    q  = sa / sb;
    r  = 16'(sa % sb);
`else
    q = a / {16'b0, b};
    r = 16'(a % {16'b0, b});
`endif
  endfunction

  // Compare process: latency, busy window, single-cycle done, results and hold.
  initial begin
    longint lhs, rhs;
    forever begin
      @(negedge clk);
      if (track) begin
        chk("busy", {63'b0, busy}, {63'b0, (!exp_z && nedge < exp_lat-1)});
        chk("done", {63'b0, done}, {63'b0, (nedge == exp_lat)});
        if (nedge == exp_lat) begin
          chk("quotient", {32'b0, quotient}, {32'b0, exp_q});
          chk("remainder", {48'b0, remainder}, {48'b0, exp_r});
          chk("div_zero", {63'b0, div_zero}, {63'b0, exp_z});
          if (!exp_z) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            lhs = longint'($signed(acc_a));
            rhs = longint'($signed(quotient)) * longint'($signed(acc_b)) + longint'($signed(remainder));
`else
            lhs = longint'(acc_a);
            rhs = longint'(quotient) * longint'(acc_b) + longint'(remainder);
`endif
            chk("invariant", rhs, lhs);
          end
          held_q = exp_q;
          held_r = exp_r;
          held_z = exp_z;
          have_result = 1'b1;
          track = 1'b0;
          finished = 1'b1;
        end
        nedge++;
      end else begin
        chk("done_idle", {63'b0, done}, 64'd0);
        if (have_result) begin
          chk("hold_q", {32'b0, quotient}, {32'b0, held_q});
          chk("hold_r", {48'b0, remainder}, {48'b0, held_r});
          chk("hold_z", {63'b0, div_zero}, {63'b0, held_z});
        end
      end
    end
  end

  task automatic run(input logic [31:0] a, input logic [15:0] b, input int poke);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    acc_a    = a;
    acc_b    = b;
    exp_z    = (b == 16'd0);
    if (b == 16'd0) begin
      exp_q   = 32'hFFFF_FFFF;
      exp_r   = a[15:0];
      exp_lat = 1;
    end else begin
      model(a, b, exp_q, exp_r);
      exp_lat = LAT;
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    finished = 1'b0;
    nedge    = 0;
    track    = 1'b1;
    for (int k = 0; k < LAT + 20 && !finished; k++) begin
      @(negedge clk);
      if (k == poke) begin
        start    = 1'b1;
        dividend = 32'd77777;
        divisor  = 16'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!finished) begin
      n_tests++;
      n_fail++;
      track = 1'b0;
      $display("FAIL timeout: no done within %0d cycles of accept", LAT + 20);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [15:0] b;

    repeat (5) @(posedge clk);
    #1;
    chk("rst_q", {32'b0, quotient}, 64'd0);
    chk("rst_r", {48'b0, remainder}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_dz", {63'b0, div_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run(32'd1800, 16'd40, -1);
    chk("lit_1800_q", {32'b0, quotient}, 64'd45);
    chk("lit_1800_r", {48'b0, remainder}, 64'd0);

    run(32'd303007, 16'd1500, -1);
    chk("lit_303007_q", {32'b0, quotient}, 64'd202);
    chk("lit_303007_r", {48'b0, remainder}, 64'd7);
    repeat (5) @(negedge clk);
    run(32'd303000, 16'd1500, -1);
    chk("lit_303000_q", {32'b0, quotient}, 64'd202);
    chk("lit_303000_r", {48'b0, remainder}, 64'd0);

    run(32'd1234, 16'd0, -1);
    chk("lit_dz_q", {32'b0, quotient}, 64'hFFFF_FFFF);
    chk("lit_dz_r", {48'b0, remainder}, 64'd1234);
    chk("lit_dz_flag", {63'b0, div_zero}, 64'd1);

    run(32'd1800, 16'd40, 5);
    chk("lit_poke_q", {32'b0, quotient}, 64'd45);
    chk("lit_poke_r", {48'b0, remainder}, 64'd0);

    // Asynchronous abort in the middle of RUN.
    @(negedge clk);
    have_result = 1'b0;
    dividend = 32'd600000;
    divisor  = 16'd77;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_q", {32'b0, quotient}, 64'd0);
    chk("abort_r", {48'b0, remainder}, 64'd0);
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_dz", {63'b0, div_zero}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run(32'd1800, 16'd40, -1);
    chk("lit_after_abort_q", {32'b0, quotient}, 64'd45);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run(32'hFFFF_8ECC, 16'd69, -1);
    chk("lit_s1_q", {32'b0, quotient}, 64'hFFFF_FE5C);
    chk("lit_s1_r", {48'b0, remainder}, 64'd0);
    run(32'hFFFF_8ECB, 16'd69, -1);
    chk("lit_s2_q", {32'b0, quotient}, 64'hFFFF_FE5C);
    chk("lit_s2_r", {48'b0, remainder}, 64'hFFFF);
    run(32'h0000_7135, 16'hFFBB, -1);
    chk("lit_s3_q", {32'b0, quotient}, 64'hFFFF_FE5C);
    chk("lit_s3_r", {48'b0, remainder}, 64'd1);
`endif

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      b = 16'($urandom);
      if (i % 4 == 0) b = 16'($urandom_range(1, 255));
      if (b == 16'd0) b = 16'd1;
      if (a == 32'h8000_0000 && b == 16'hFFFF) b = 16'd1;
      run(a, b, -1);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider: the inverse datapath of the shift-and-add multiplier.
- Takes a 2W-bit dividend and a W-bit divisor; returns a 2W-bit quotient and a W-bit remainder after a fixed number of cycles.
- Uses the same start-pulse / result-hold interface style as the multiplier, so a multiplier product can be fed back in to recover the operand (mult / y = x).

Parameters:
- W, 16, divisor and remainder width; dividend and quotient are 2W bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- dividend  in  2W  numerator; sampled on the accepting edge.
- divisor  in  W  denominator; sampled on the accepting edge.
- quotient  out  2W  result; held until the next accepted start.
- remainder  out  W  result; held until the next accepted start.
- busy  out  1  high from the accepting edge until done.
- done  out  1  single-cycle completion pulse.
- div_zero  out  1  divisor was 0; held with the results.

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-high (rst).
- Reset (async assert, any state): state=IDLE; quotient, remainder, busy, done, div_zero = 0; internal registers cleared.
- Reset mid-operation aborts the division. No partial result is exposed.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge, divisor!=0:
  - latch dividend into shift register Q and divisor into D;
  - clear partial remainder R (W+1 bits);
  - count=2W-1; busy=1; go to RUN.
- IDLE, start=1 at edge, divisor==0:
  - go to DONE directly;
  - quotient = all ones; remainder = dividend[W-1:0]; div_zero=1.
- RUN, one step per clock:
  - R' = {R[W-1:0], Q[MSB]}; Q <<= 1.
  - If R' >= D: R = R' - D and Q[0]=1; otherwise R = R' and Q[0]=0.
  - count decrements; at count==0 after the step, go to DONE.
- DONE, one cycle:
  - quotient=Q, remainder=R[W-1:0], done=1, busy=0;
  - then unconditionally return to IDLE.
- Latency: done rises 2W+1 edges after the accepting edge (33 for W=16); divide-by-zero gives 1 edge.
- done is high for exactly 1 cycle. Outputs hold their value after done until the next accepted start.
- start in RUN or DONE is ignored (no queueing). start held high re-triggers on the first IDLE cycle after DONE.
- Inputs are don't-care except on the accepting edge.
- Unsigned arithmetic by default. The remainder always fits W bits because it is < divisor.
- Invariant: dividend == quotient*divisor + remainder for divisor != 0 and quotient < 2^(2W).

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - operands are two's complement;
  - on accept, magnitudes are taken and the signs latched;
  - the same unsigned core runs, plus one extra FIX cycle before DONE;
  - in FIX, quotient is negated if the sign bits differ, and remainder takes the dividend's sign (truncation toward zero);
  - latency 2W+2;
  - divisor==0 behaviour is unchanged; results are raw, with no sign fix.
- Undefined:
  - purely unsigned; no FIX state; latency 2W+1.

Decomposition:
- Package seq_divider_pkg:
  - state enum typedef (IDLE, RUN, FIX, DONE);
  - default width constant;
  - count-width function $clog2(2W).
- Sub-module div_step: combinational single restoring iteration, inputs R, next bit, D; outputs new R and quotient bit.
- FSM, counter and output registers stay in seq_divider.

Test Plan:
- dividend=1800, divisor=40, start pulse after 5 reset cycles -> done 33 edges later; quotient=45, remainder=0, div_zero=0; busy high for 32 cycles.
- dividend=303007, divisor=1500 -> quotient=202, remainder=7; re-run with 303000 -> quotient=202, remainder=0. Outputs hold between runs.
- dividend=1234, divisor=0 -> done 1 edge after accept; div_zero=1, quotient=32'hFFFF_FFFF, remainder=1234.
- start pulse mid-RUN with other operands -> ignored; first result unchanged. Assert rst asynchronously at cycle 10 of RUN -> all outputs 0 immediately and no done; fresh 1800/40 afterwards gives 45.
- SEQ_DIVIDER_SIGNED_EN defined:
  - -28980/69 -> quotient=-420, remainder=0, latency 34;
  - -28981/69 -> quotient=-420, remainder=-1;
  - 28981/-69 -> quotient=-420, remainder=1.
- Randomised back-to-back loop of 200 pairs with divisor!=0 -> invariant holds on every done pulse; each done high exactly one cycle.
